// File: rtl/i2c_master_burst.sv
// i2c_master_burst: single-master I2C burst read/write engine.
// Counter-timed SCL, open-drain SDA, no clock stretching.
module i2c_master_burst #(
    parameter int DIV_STD  = 80,
    parameter int DIV_FAST = 20,
    parameter int LEN_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire              SDA,
    output logic             SCL,
    input  logic             start,
    input  logic             speed,
    input  logic             rw,
    input  logic [6:0]       addr,
    input  logic [LEN_W-1:0] nbytes,
    input  logic [7:0]       wdata,
    output logic             wr_req,
    output logic [7:0]       rdata,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             nack
);

    localparam int MAXD = (DIV_STD > DIV_FAST) ? DIV_STD : DIV_FAST;
    localparam int CW   = $clog2(MAXD + 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE,
        WRITE_ACK, READ, READ_ACK, STOP
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     div;
    logic              sda_oe;
    logic [7:0]        tx;
    logic [7:0]        wbuf;
    logic [7:0]        rx;
    logic [2:0]        bidx;
    logic [LEN_W-1:0]  left;
    logic              rw_q;
    logic              ack_q;
    logic              sp;
    logic              last;
    logic              mid;

    assign SDA  = sda_oe ? 1'b0 : 1'bz;
    assign last = (cnt == div - 1'b1);
    assign mid  = (cnt == (div >> 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            div      <= CW'(DIV_STD);
            sda_oe   <= 1'b0;
            SCL      <= 1'b1;
            tx       <= '0;
            wbuf     <= '0;
            rx       <= '0;
            bidx     <= '0;
            left     <= '0;
            rw_q     <= 1'b0;
            ack_q    <= 1'b0;
            sp       <= 1'b0;
            wr_req   <= 1'b0;
            rdata    <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
        end else begin
            wr_req   <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (wr_req) tx <= wdata;
            if (state != IDLE) cnt <= last ? '0 : cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= START;
                        busy   <= 1'b1;
                        nack   <= 1'b0;
                        div    <= speed ? CW'(DIV_FAST) : CW'(DIV_STD);
                        rw_q   <= rw;
                        left   <= nbytes;
                        tx     <= {addr, rw};
                        wbuf   <= wdata;
                        sda_oe <= 1'b1;
                        cnt    <= '0;
                    end
                end
                START: begin
                    if (last) begin
                        SCL   <= 1'b0;
                        bidx  <= 3'd7;
                        state <= ADDR;
                    end
                end
                ADDR, WRITE: begin
                    if (!SCL && mid) sda_oe <= ~tx[bidx];
                    if (last) begin
                        SCL <= ~SCL;
                        if (SCL) begin
                            bidx <= bidx - 1'b1;
                            if (bidx == 3'd0) begin
                                state <= (state == ADDR) ? ADDR_ACK : WRITE_ACK;
                                if (state == WRITE && left != 0)
                                    left <= left - 1'b1;
                            end
                        end
                    end
                end
                ADDR_ACK, WRITE_ACK: begin
                    if (!SCL && mid) sda_oe <= 1'b0;
                    if (SCL && mid) ack_q <= SDA;
                    if (last) begin
                        SCL <= ~SCL;
                        // decision taken on the falling edge that ends the ACK bit
                        if (SCL) begin
                            if (ack_q) begin
                                nack  <= 1'b1;
                                state <= STOP;
                            end else if (left == 0) begin
                                state <= STOP;
                            end else if (state == WRITE_ACK) begin
                                wr_req <= 1'b1;
                                state  <= WRITE;
                            end else if (rw_q) begin
                                state <= READ;
                            end else begin
                                tx    <= wbuf;
                                state <= WRITE;
                            end
                        end
                    end
                end
                READ: begin
                    if (!SCL && mid) sda_oe <= 1'b0;
                    if (SCL && mid) begin
                        rx <= {rx[6:0], SDA};
                        if (bidx == 3'd0) begin
                            rdata    <= {rx[6:0], SDA};
                            rd_valid <= 1'b1;
                            if (left != 0) left <= left - 1'b1;
                        end
                    end
                    if (last) begin
                        SCL <= ~SCL;
                        if (SCL) begin
                            bidx <= bidx - 1'b1;
                            if (bidx == 3'd0) state <= READ_ACK;
                        end
                    end
                end
                READ_ACK: begin
                    if (!SCL && mid) sda_oe <= (left != 0);
                    if (last) begin
                        SCL <= ~SCL;
                        if (SCL) state <= (left != 0) ? READ : STOP;
                    end
                end
                STOP: begin
                    if (!SCL) begin
                        if (mid) sda_oe <= 1'b1;
                        if (last) SCL <= 1'b1;
                    end else if (!sp) begin
                        if (mid) begin
                            sda_oe <= 1'b0;
                            sp     <= 1'b1;
                            cnt    <= '0;
                        end
                    end else if (last) begin
                        sp    <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_burst.sv
// Directed bench for i2c_master_burst: a table of bus transactions
// run against a behavioural slave, plus reset and strobe corner cases.
module tb_i2c_master_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    wire        SDA;
    logic       SCL;
    logic       start = 1'b0;
    logic       speed = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [3:0] nbytes = '0;
    logic [7:0] wdata = '0;
    logic       wr_req;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       nack;

    logic sl_low = 1'b0;
    logic sda_bit;
    assign SDA = sl_low ? 1'b0 : 1'bz;
    pullup (SDA);
    assign sda_bit = (SDA === 1'b0) ? 1'b0 : 1'b1;

    i2c_master_burst dut (
        .clk(clk), .rst(rst), .SDA(SDA), .SCL(SCL),
        .start(start), .speed(speed), .rw(rw), .addr(addr),
        .nbytes(nbytes), .wdata(wdata), .wr_req(wr_req),
        .rdata(rdata), .rd_valid(rd_valid), .busy(busy),
        .done(done), .nack(nack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rw;
        logic            speed;
        logic [6:0]      addr;
        logic [3:0]      n;
        logic [3:0][7:0] d;
        logic [4:0]      ack;
        int              exp_wr;
        int              exp_rd;
        logic            exp_nack;
        int              exp_per;
    } vec_t;

    vec_t vecs[7];
    int   total = 0;
    int   bad = 0;
    logic abort = 1'b0;

    int         cyc = 0;
    int         wrc = 0;
    int         rdc = 0;
    int         donec = 0;
    int         starts = 0;
    int         stops = 0;
    logic       pscl = 1'b1;
    logic       psda = 1'b1;
    logic [7:0] rdq [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_req) wrc <= wrc + 1;
        if (rd_valid) begin
            rdq[rdc[5:0]] <= rdata;
            rdc <= rdc + 1;
        end
        if (done) donec <= donec + 1;
        if (SCL && pscl && psda && !sda_bit) starts <= starts + 1;
        if (SCL && pscl && !psda && sda_bit) stops <= stops + 1;
        pscl <= SCL;
        psda <= sda_bit;
    end

    function automatic vec_t mk(input logic r, input logic s,
                                input logic [6:0] a, input logic [3:0] n,
                                input logic [31:0] d, input logic [4:0] ack,
                                input int wr, input int rd,
                                input logic nk, input int per);
        vec_t v;
        v.rw = r; v.speed = s; v.addr = a; v.n = n; v.d = d;
        v.ack = ack; v.exp_wr = wr; v.exp_rd = rd;
        v.exp_nack = nk; v.exp_per = per;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, got, exp);
        end
    endtask

    task automatic wait_scl(input logic lv);
        int n = 0;
        if (abort) return;
        while (SCL !== lv && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (SCL !== lv) begin
            total++;
            bad++;
            abort = 1'b1;
            $display("FAIL scl_timeout got=%0b want=%0b", SCL, lv);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b, output int t0, output int t1);
        b = '0; t0 = 0; t1 = 0;
        for (int j = 0; j < 8; j++) begin
            wait_scl(1'b1);
            if (j == 0) t0 = cyc;
            if (j == 1) t1 = cyc;
            b = {b[6:0], sda_bit};
            wait_scl(1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int j = 0; j < 8; j++) begin
            sl_low = ~b[7-j];
            wait_scl(1'b1);
            wait_scl(1'b0);
        end
        sl_low = 1'b0;
    endtask

    task automatic ack_bit(input logic a);
        sl_low = a;
        wait_scl(1'b1);
        wait_scl(1'b0);
        sl_low = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!abort && done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic kick(input vec_t v);
        @(negedge clk);
        rw = v.rw; speed = v.speed; addr = v.addr;
        nbytes = v.n; wdata = v.d[0]; start = 1'b1;
        @(negedge clk);
        // stray strobe with a different command while busy
        addr = 7'h00; rw = ~v.rw;
        chk("busy_on", int'(busy), 1);
        chk("nack_clr", int'(nack), 0);
        @(negedge clk);
        start = 1'b0;
        wdata = v.d[1];
    endtask

    task automatic recover();
        if (abort) begin
            sl_low = 1'b0;
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            abort = 1'b0;
        end
    endtask

    task automatic run_vec(input int i);
        vec_t       v;
        logic [7:0] b;
        int         t0, t1;
        int         wr0, rd0, st0, sa0;
        v = vecs[i];
        wr0 = wrc; rd0 = rdc; st0 = stops; sa0 = starts;
        kick(v);
        wait_scl(1'b0);
        recv_byte(b, t0, t1);
        chk("addr_byte", int'(b), int'({v.addr, v.rw}));
        chk("bit_period", t1 - t0, v.exp_per);
        ack_bit(v.ack[0]);
        if (v.ack[0]) begin
            for (int k = 0; k < int'(v.n); k++) begin
                if (!v.rw) begin
                    recv_byte(b, t0, t1);
                    chk("wr_byte", int'(b), int'(v.d[k]));
                    wdata = v.d[k+1];
                    ack_bit(v.ack[k+1]);
                    if (!v.ack[k+1]) break;
                end else begin
                    send_byte(v.d[k]);
                    wait_scl(1'b1);
                    chk("m_ack", int'(sda_bit), (k == int'(v.n) - 1) ? 1 : 0);
                    wait_scl(1'b0);
                end
            end
        end
        wait_done();
        chk("busy_at_done", int'(busy), 0);
        chk("nack_at_done", int'(nack), int'(v.exp_nack));
        chk("stop_before_done", stops - st0, 1);
        chk("start_count", starts - sa0, 1);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        repeat (4) @(negedge clk);
        chk("nack_held", int'(nack), int'(v.exp_nack));
        chk("wr_req_count", wrc - wr0, v.exp_wr);
        chk("rd_valid_count", rdc - rd0, v.exp_rd);
        for (int k = 0; k < v.exp_rd; k++)
            chk("rd_data", int'(rdq[6'(rd0 + k)]), int'(v.d[k]));
        if (v.exp_rd > 0)
            chk("rdata_held", int'(rdata), int'(v.d[v.exp_rd-1]));
        recover();
    endtask

    initial begin
        logic [7:0] b;
        int         t0, t1;
        int         d0;
        vec_t       rv;

        vecs[0] = mk(0, 0, 7'h50, 2, 32'h0000_3CA5, 5'b00111, 1, 0, 0, 160);
        vecs[1] = mk(1, 0, 7'h68, 3, 32'h0033_2211, 5'b00001, 0, 3, 0, 160);
        vecs[2] = mk(0, 0, 7'h7F, 2, 32'h0000_6655, 5'b00000, 0, 0, 1, 160);
        vecs[3] = mk(0, 0, 7'h3A, 3, 32'h0056_3412, 5'b00011, 1, 0, 1, 160);
        vecs[4] = mk(0, 1, 7'h2A, 0, 32'h0000_0000, 5'b00001, 0, 0, 0, 40);
        vecs[5] = mk(1, 1, 7'h33, 0, 32'h0000_0000, 5'b00000, 0, 0, 1, 40);
        vecs[6] = mk(1, 1, 7'h45, 1, 32'h0000_00C3, 5'b00001, 0, 1, 0, 40);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_scl", int'(SCL), 1);
        chk("rst_sda", int'(sda_bit), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_nack", int'(nack), 0);
        chk("rst_wr_req", int'(wr_req), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rdata", int'(rdata), 0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // reset in the middle of bit 4 of the first read byte
        rv = vecs[1];
        kick(rv);
        wait_scl(1'b0);
        recv_byte(b, t0, t1);
        ack_bit(1'b1);
        for (int j = 0; j < 4; j++) begin
            sl_low = ~rv.d[0][7-j];
            wait_scl(1'b1);
            wait_scl(1'b0);
        end
        sl_low = 1'b0;
        repeat (10) @(negedge clk);
        d0 = donec;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_scl", int'(SCL), 1);
        chk("mid_rst_sda", int'(sda_bit), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_rdata", int'(rdata), 0);
        chk("mid_rst_rd_valid", int'(rd_valid), 0);
        repeat (300) @(negedge clk);
        chk("mid_rst_no_done", donec - d0, 0);
        chk("mid_rst_idle_scl", int'(SCL), 1);
        abort = 1'b0;

        run_vec(0);
        run_vec(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
